// File: rtl/seatbelt_chime_ctrl_pkg.sv
// Shared types and default parameters for the seat-belt chime controller.
package seatbelt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHIME = 2'd1,
    ST_QUIET = 2'd2
  } state_t;

  localparam int DEF_DB_CYCLES   = 4;
  localparam int DEF_HALF_PERIOD = 8;
  localparam int DEF_BEEP_COUNT  = 6;

endpackage

// File: rtl/seatbelt_chime_ctrl_debounce_filter.sv
// Two-flop synchronizer followed by a stability counter for one raw switch.
module debounce_filter
  import seatbelt_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // Synchronize, then accept a new level only after DB_CYCLES mismatching cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES)) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seatbelt_chime_ctrl.sv
// Driver-warning sequencer: debounced switches -> warning condition -> timed chime + lamp.
module seatbelt_chime_ctrl
  import seatbelt_pkg::*;
#(
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int HALF_PERIOD = DEF_HALF_PERIOD,
  parameter int BEEP_COUNT  = DEF_BEEP_COUNT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       door_close,
  input  logic       ignition,
  input  logic       seat_belt,
  output logic       warn_cond,
  output logic       chime,
  output logic       lamp,
  output logic [1:0] state
);

  localparam int PW = $clog2(HALF_PERIOD + 1);
  localparam int BW = $clog2(BEEP_COUNT + 1);

  // bit 0 door, bit 1 ignition, bit 2 belt
  logic [2:0] raw, db;
  assign raw = {seat_belt, ignition, door_close};

  debounce_filter #(.DB_CYCLES(DB_CYCLES)) u_db [2:0] (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (raw),
    .db   (db)
  );

  state_t        st_q, st_d;
  logic          chime_d, lamp_d;
  logic [PW-1:0] phase, phase_d;
  logic [BW-1:0] beep, beep_d;

  // Warn when ignition is on and either the door is open or the belt is unbuckled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) warn_cond <= 1'b0;
    else        warn_cond <= db[1] & (~db[0] | ~db[2]);
  end

  // FSM and chime timing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= ST_IDLE;
      chime <= 1'b0;
      lamp  <= 1'b0;
      phase <= '0;
      beep  <= '0;
    end else begin
      st_q  <= st_d;
      chime <= chime_d;
      lamp  <= lamp_d;
      phase <= phase_d;
      beep  <= beep_d;
    end
  end

  // Next state; beep counts falling toggles, episode ends when the last low half completes.
  always_comb begin
    st_d    = st_q;
    chime_d = chime;
    lamp_d  = lamp;
    phase_d = phase;
    beep_d  = beep;
    case (st_q)
      ST_IDLE: begin
        chime_d = 1'b0;
        lamp_d  = 1'b0;
        if (warn_cond) begin
          st_d    = ST_CHIME;
          chime_d = 1'b1;
          lamp_d  = 1'b1;
          phase_d = '0;
          beep_d  = '0;
        end
      end
      ST_CHIME: begin
        lamp_d = 1'b1;
        if (!warn_cond) begin
          st_d    = ST_IDLE;
          chime_d = 1'b0;
          lamp_d  = 1'b0;
        end else if (phase == PW'(HALF_PERIOD - 1)) begin
          phase_d = '0;
          if (chime) begin
            chime_d = 1'b0;
            beep_d  = beep + 1'b1;
          end else if (beep == BW'(BEEP_COUNT)) begin
            st_d    = ST_QUIET;
            chime_d = 1'b0;
          end else begin
            chime_d = 1'b1;
          end
        end else begin
          phase_d = phase + 1'b1;
        end
      end
      ST_QUIET: begin
        chime_d = 1'b0;
        lamp_d  = 1'b1;
        if (!warn_cond) begin
          st_d   = ST_IDLE;
          lamp_d = 1'b0;
        end
      end
      default: begin
        st_d    = ST_IDLE;
        chime_d = 1'b0;
        lamp_d  = 1'b0;
      end
    endcase
  end

  assign state = st_q;

endmodule

// File: tb/tb_seatbelt_chime_ctrl.sv
// Scoreboard bench: stimulus pushes cycle-stamped expectations, a negedge monitor compares.
module tb_seatbelt_chime_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       door_close = 1'b0, ignition = 1'b0, seat_belt = 1'b0;
  logic       warn_cond, chime, lamp;
  logic [1:0] state;

  seatbelt_chime_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .door_close(door_close),
    .ignition  (ignition),
    .seat_belt (seat_belt),
    .warn_cond (warn_cond),
    .chime     (chime),
    .lamp      (lamp),
    .state     (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [4:0] v;   // {warn, chime, lamp, state}
    string      nm;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   base;

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got warn/chime/lamp/state=%b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic ex(input int n, input logic w, input logic c, input logic l,
                    input logic [1:0] s, input string nm);
    exp_t e;
    e.cyc = base + n;
    e.v   = {w, c, l, s};
    e.nm  = nm;
    q.push_back(e);
  endtask

  // Drive raw switches just after a clock edge; the next edge is edge 0.
  task automatic apply(input logic d, input logic i, input logic b);
    @(posedge clk); #1;
    base = cyc + 1;
    door_close = d;
    ignition   = i;
    seat_belt  = b;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while (q.size() > 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d expectations pending, required 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: compare every expectation stamped for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      if (q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cyc %0d not sampled (now %0d)", q[0].nm, q[0].cyc, cyc);
      end else begin
        chk(q[0].nm, {warn_cond, chime, lamp, state}, q[0].v);
      end
      void'(q.pop_front());
    end
  end

  int a0;

  initial begin
    #12;
    chk("reset_state", {warn_cond, chime, lamp, state}, 5'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic episode: ignition on, door closed, belt open.
    apply(1, 1, 0);
    ex(6, 0, 0, 0, 0, "basic_before_warn");
    ex(7, 1, 0, 0, 0, "basic_warn");
    for (int k = 0; k < 6; k++) begin
      ex(8 + 16*k,  1, 1, 1, 1, "basic_hi_first");
      ex(15 + 16*k, 1, 1, 1, 1, "basic_hi_last");
      ex(16 + 16*k, 1, 0, 1, 1, "basic_lo_first");
      ex(23 + 16*k, 1, 0, 1, 1, "basic_lo_last");
    end
    ex(104, 1, 0, 1, 2, "basic_quiet");
    ex(120, 1, 0, 1, 2, "basic_quiet_hold");
    drain(300);

    // Re-trigger: ignition off from QUIET, then back on.
    apply(1, 0, 0);
    ex(7, 0, 0, 1, 2, "ignoff_quiet_hold");
    ex(8, 0, 0, 0, 0, "ignoff_idle");
    drain(50);
    apply(1, 1, 0);
    ex(7, 1, 0, 0, 0, "retrig_warn");
    ex(8, 1, 1, 1, 1, "retrig_start");
    ex(23, 1, 0, 1, 1, "retrig_lo");
    ex(24, 1, 1, 1, 1, "retrig_beep2");
    ex(103, 1, 0, 1, 1, "retrig_last_low");
    ex(104, 1, 0, 1, 2, "retrig_quiet");
    drain(300);

    // Door-open path.
    apply(1, 1, 1);
    ex(7, 0, 0, 1, 2, "buckle_quiet_hold");
    ex(8, 0, 0, 0, 0, "buckle_idle");
    drain(50);
    apply(0, 1, 1);
    ex(7, 1, 0, 0, 0, "door_warn");
    ex(8, 1, 1, 1, 1, "door_start");
    ex(104, 1, 0, 1, 2, "door_quiet");
    drain(300);
    apply(1, 1, 1);
    ex(7, 0, 0, 1, 2, "door_close_hold");
    ex(8, 0, 0, 0, 0, "door_close_idle");
    drain(50);

    // Three-cycle belt glitch must be rejected.
    apply(1, 1, 0);
    for (int n = 0; n <= 14; n += 2) ex(n, 0, 0, 0, 0, "glitch_rejected");
    repeat (3) @(posedge clk);
    #1 seat_belt = 1'b1;
    drain(50);

    // Buckle mid-chime, landing inside the third beep's high half.
    apply(1, 1, 0);
    a0 = base + 8;
    ex(8, 1, 1, 1, 1, "midbuckle_start");
    wait_cyc(a0 + 28);
    apply(1, 1, 1);
    ex(7, 0, 1, 1, 1, "midbuckle_pre");
    ex(8, 0, 0, 0, 0, "midbuckle_idle");
    drain(50);

    // warn_cond drops on the final beep completion: IDLE wins over QUIET.
    apply(1, 1, 0);
    a0 = base + 8;
    ex(8, 1, 1, 1, 1, "race_start");
    wait_cyc(a0 + 86);
    apply(1, 1, 1);
    ex(7, 0, 0, 1, 1, "race_last_low");
    ex(8, 0, 0, 0, 0, "race_idle");
    drain(50);

    // Asynchronous reset mid-episode, then restart with inputs held.
    apply(1, 1, 0);
    a0 = base;
    ex(8, 1, 1, 1, 1, "rst_pre_chime");
    wait_cyc(a0 + 10);
    rst_n = 1'b0;
    #1 chk("rst_async_clear", {warn_cond, chime, lamp, state}, 5'b0);
    repeat (2) @(posedge clk);
    #1 chk("rst_held", {warn_cond, chime, lamp, state}, 5'b0);
    rst_n = 1'b1;
    base = cyc + 1;
    ex(7, 1, 0, 0, 0, "rst_rel_warn");
    ex(8, 1, 1, 1, 1, "rst_rel_restart");
    drain(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
